pwm_multi_gen: RTL and testbench

Multi-channel, parametrised successor to the single-channel PWM tone generator. It runs NUM_CH independent PWM channels from one shared prescaler. Each channel supports edge- or center-aligned counting, glitch-free double-buffered duty updates, and output inversion. The block also mixes the channel levels into one signed audio sample for the codec path. It sits between the control/register logic and the audio output stage, in a single clock domain.

---
 rtl/pwm_multi_pkg.sv | 29 ++
 rtl/pwm_channel.sv | 81 ++++++++
 rtl/pwm_multi_gen.sv | 93 +++++++++
 tb/tb_pwm_multi_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_multi_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Per-channel mixer amplitude so that NUM_CH full-scale contributions fit the sample width.
  function automatic longint unsigned mix_level(input int unsigned sample_width,
                                                input int unsigned num_ch);
    return ((64'd1 << (sample_width - 1)) - 64'd1) >> clog2(num_ch);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, edge/center counter, compare and output invert.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_i,
  input  logic                 enable_i,
  input  logic                 center_i,
  input  logic                 invert_i,
  input  logic                 wr_hit_i,
  input  logic [CNT_WIDTH:0]   wr_data_i,
  output logic                 lvl_o,
  output logic                 pwm_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  dir_e                 dir_q, dir_d;
  logic [CNT_WIDTH:0]   shadow_q, shadow_d;
  logic [CNT_WIDTH:0]   active_q, active_d;
  logic                 pwm_q, pwm_d;
  logic                 boundary;
  mode_e                mode;

  always_comb begin
    mode     = mode_e'(center_i);
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    active_d = active_q;
    boundary = 1'b0;
    shadow_d = wr_hit_i ? wr_data_i : shadow_q;
    lvl_o    = enable_i && ({1'b0, cnt_q} < active_q);
    pwm_d    = lvl_o ^ invert_i;

    if (!enable_i) begin
      cnt_d    = '0;
      dir_d    = DIR_UP;
      active_d = shadow_q;
    end else if (tick_i) begin
      // Edge mode pins dir to up, so a later switch to center resumes counting upward.
      if (mode == MODE_EDGE) begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = cnt_q + 1'b1;
        dir_d    = DIR_UP;
      end else begin
        boundary = (cnt_q == '0) && (dir_q == DIR_DOWN);
        if (dir_q == DIR_UP) begin
          if (cnt_q == CNT_MAX) dir_d = DIR_DOWN;
          else                  cnt_d = cnt_q + 1'b1;
        end else begin
          if (cnt_q == '0) dir_d = DIR_UP;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      if (boundary) active_d = wr_hit_i ? wr_data_i : shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaler, duty write decode, channel array and sample mixer.
module pwm_multi_gen
  import pwm_multi_pkg::*;
#(
  parameter  int unsigned NUM_CH         = 4,
  parameter  int unsigned CNT_WIDTH      = 8,
  parameter  int unsigned PRESCALE_WIDTH = 16,
  parameter  int unsigned SAMPLE_WIDTH   = 24,
  localparam int unsigned AW             = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [CNT_WIDTH:0]        wr_data,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         ch_center,
  input  logic [NUM_CH-1:0]         ch_invert,
  input  logic                      sample_en,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic [SAMPLE_WIDTH-1:0]   sample_out,
  output logic                      sample_valid
);

  localparam logic [CNT_WIDTH:0] DUTY_FULL = {1'b1, {CNT_WIDTH{1'b0}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] LEVEL = SAMPLE_WIDTH'(mix_level(SAMPLE_WIDTH, NUM_CH));

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, presc_last;
  logic                      tick;
  logic [CNT_WIDTH:0]        wr_data_sat;
  logic [NUM_CH-1:0]         wr_hit;
  logic [NUM_CH-1:0]         lvl;
  logic signed [SAMPLE_WIDTH-1:0] mix;
  logic [SAMPLE_WIDTH-1:0]   sample_q, sample_d;
  logic                      valid_q;

  // Comparing with >= lets a shrinking prescale wrap on the next cycle instead of running to overflow.
  always_comb begin
    presc_last = (prescale == '0) ? '0 : prescale - 1'b1;
    tick       = (presc_q >= presc_last);
    presc_d    = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    wr_data_sat = (wr_data > DUTY_FULL) ? DUTY_FULL : wr_data;
    wr_hit      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en && (32'(wr_addr) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_i    (tick),
      .enable_i  (ch_enable[g]),
      .center_i  (ch_center[g]),
      .invert_i  (ch_invert[g]),
      .wr_hit_i  (wr_hit[g]),
      .wr_data_i (wr_data_sat),
      .lvl_o     (lvl[g]),
      .pwm_o     (pwm_out[g])
    );
  end

  always_comb begin
    mix = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_enable[i]) mix = lvl[i] ? (mix + LEVEL) : (mix - LEVEL);
    end
    sample_d = sample_en ? mix : sample_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sample_q <= sample_d;
      valid_q  <= sample_en;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed period checks, mixer vector table, random run vs model.
module tb_pwm_multi_gen;

  localparam int NCH   = 4;
  localparam int FULL  = 16;
  localparam int LEVEL = ((1 << 23) - 1) >> 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] prescale;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [3:0]  ch_enable, ch_center, ch_invert;
  logic        sample_en;
  logic [3:0]  pwm_out;
  logic [23:0] sample_out;
  logic        sample_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_multi_gen #(
    .NUM_CH         (4),
    .CNT_WIDTH      (4),
    .PRESCALE_WIDTH (16),
    .SAMPLE_WIDTH   (24)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .prescale     (prescale),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ch_enable    (ch_enable),
    .ch_center    (ch_center),
    .ch_invert    (ch_invert),
    .sample_en    (sample_en),
    .pwm_out      (pwm_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int duty);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 2'(ch); wr_data = 5'(duty);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(pwm_out[ch]);
    end
  endtask

  // Reference model: counter position derived from tick count within the current enabled run.
  int          m_presc;
  int          m_k[NCH];
  int          m_shadow[NCH];
  int          m_active[NCH];
  logic [3:0]  m_pwm;
  logic [23:0] m_sample;
  logic        m_valid;

  function automatic int period_of(input bit ctr);
    return ctr ? 2 * FULL : FULL;
  endfunction

  function automatic int cnt_of(input int k, input bit ctr);
    int ph;
    ph = k % period_of(ctr);
    if (!ctr) return ph;
    return (ph < FULL) ? ph : (2 * FULL - 1 - ph);
  endfunction

  task automatic model_reset();
    m_presc = 0; m_pwm = '0; m_sample = '0; m_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_k[i] = 0; m_shadow[i] = 0; m_active[i] = 0;
    end
  endtask

  task automatic model_step();
    int  p, sum, wd;
    bit  tick, lvl, hit, bnd;
    logic [3:0] pwm_n;
    p    = (prescale == 0) ? 1 : int'(prescale);
    tick = (m_presc >= p - 1);
    sum  = 0;
    wd   = (int'(wr_data) > FULL) ? FULL : int'(wr_data);
    for (int i = 0; i < NCH; i++) begin
      lvl = ch_enable[i] && (cnt_of(m_k[i], ch_center[i]) < m_active[i]);
      if (ch_enable[i]) sum += lvl ? LEVEL : -LEVEL;
      pwm_n[i] = lvl ^ ch_invert[i];
      hit = wr_en && (int'(wr_addr) == i);
      bnd = ch_enable[i] && tick &&
            ((m_k[i] % period_of(ch_center[i])) == period_of(ch_center[i]) - 1);
      if (!ch_enable[i]) m_active[i] = m_shadow[i];
      else if (bnd)      m_active[i] = hit ? wd : m_shadow[i];
      if (hit) m_shadow[i] = wd;
      if (!ch_enable[i]) m_k[i] = 0;
      else if (tick)     m_k[i] = (m_k[i] + 1) % period_of(ch_center[i]);
    end
    m_presc = tick ? 0 : m_presc + 1;
    m_pwm   = pwm_n;
    if (sample_en) m_sample = 24'(sum);
    m_valid = sample_en;
  endtask

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0]      inv;
    logic [3:0][4:0] duty;
    logic [3:0]      exp_pwm;
    logic [23:0]     exp_sample;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ones;
    vecs[0] = '{en:4'hF, inv:4'h0, duty:{5'd16, 5'd16, 5'd16, 5'd16}, exp_pwm:4'hF, exp_sample:24'd8388604};
    vecs[1] = '{en:4'hF, inv:4'h0, duty:{5'd0,  5'd0,  5'd16, 5'd16}, exp_pwm:4'h3, exp_sample:24'd0};
    vecs[2] = '{en:4'hE, inv:4'h0, duty:{5'd16, 5'd16, 5'd16, 5'd16}, exp_pwm:4'hE, exp_sample:24'd6291453};
    vecs[3] = '{en:4'hF, inv:4'hF, duty:{5'd0,  5'd0,  5'd0,  5'd0 }, exp_pwm:4'hF, exp_sample:24'h800004};
    vecs[4] = '{en:4'h0, inv:4'h5, duty:{5'd16, 5'd16, 5'd16, 5'd16}, exp_pwm:4'h5, exp_sample:24'd0};
    vecs[5] = '{en:4'h3, inv:4'h2, duty:{5'd16, 5'd16, 5'd0,  5'd16}, exp_pwm:4'h3, exp_sample:24'd0};

    reset_n = 1'b0; prescale = 16'd1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ch_enable = '0; ch_center = '0; ch_invert = '0; sample_en = 1'b0;
    idle(3);
    check("reset_pwm_out", 64'(pwm_out), 64'd0);
    check("reset_sample_out", 64'(sample_out), 64'd0);
    check("reset_sample_valid", 64'(sample_valid), 64'd0);
    reset_n = 1'b1;

    // Edge-aligned duty 4, prescale 1 then 3.
    do_write(0, 4);
    idle(3);
    ch_enable[0] = 1'b1;
    idle(20);
    count_high(0, 16, ones);
    check("edge_duty4_p1_high", 64'(ones), 64'd4);
    prescale = 16'd3;
    idle(60);
    count_high(0, 48, ones);
    check("edge_duty4_p3_high", 64'(ones), 64'd12);
    prescale = 16'd1;
    ch_enable[0] = 1'b0;

    // Constant levels on ch1 with invert toggled.
    do_write(1, 0);
    idle(3);
    ch_enable[1] = 1'b1; ch_invert[1] = 1'b1;
    idle(3);
    count_high(1, 32, ones);
    check("ch1_duty0_inv1", 64'(ones), 64'd32);
    ch_invert[1] = 1'b0;
    idle(1);
    count_high(1, 32, ones);
    check("ch1_duty0_inv0", 64'(ones), 64'd0);
    do_write(1, 16);
    idle(20);
    count_high(1, 32, ones);
    check("ch1_duty16_inv0", 64'(ones), 64'd32);
    ch_invert[1] = 1'b1;
    idle(1);
    count_high(1, 32, ones);
    check("ch1_duty16_inv1", 64'(ones), 64'd0);
    ch_enable[1] = 1'b0; ch_invert[1] = 1'b0;

    // Center-aligned duty 4: 8 high cycles per 32-cycle period.
    do_write(3, 4);
    idle(3);
    ch_center[3] = 1'b1; ch_enable[3] = 1'b1;
    idle(40);
    count_high(3, 32, ones);
    check("center_duty4_high", 64'(ones), 64'd8);
    ch_enable = '0; ch_center = '0;

    // Mixer vector table.
    for (int v = 0; v < 6; v++) begin
      ch_enable = '0; ch_invert = '0;
      for (int c = 0; c < NCH; c++) do_write(c, int'(vecs[v].duty[c]));
      idle(2);
      ch_enable = vecs[v].en; ch_invert = vecs[v].inv;
      idle(3);
      sample_en = 1'b1;
      idle(1);
      sample_en = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", v), 64'(sample_valid), 64'd1);
      check($sformatf("vec%0d_sample", v), 64'(sample_out), 64'(vecs[v].exp_sample));
      check($sformatf("vec%0d_pwm", v), 64'(pwm_out), 64'(vecs[v].exp_pwm));
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", v), 64'(sample_valid), 64'd0);
      check($sformatf("vec%0d_sample_hold", v), 64'(sample_out), 64'(vecs[v].exp_sample));
      @(posedge clk); #1;
    end

    // Random run against the reference model, with an asynchronous reset mid-run.
    reset_n = 1'b0;
    ch_enable = '0; ch_center = '0; ch_invert = '0; sample_en = 1'b0; wr_en = 1'b0;
    prescale = 16'd1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_step();
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk); #1;
      wr_en     = ($urandom % 4) == 0;
      wr_addr   = 2'($urandom % 4);
      wr_data   = 5'($urandom % 32);
      sample_en = ($urandom % 3) == 0;
      for (int c = 0; c < NCH; c++) begin
        if (($urandom % 64) == 0) ch_enable[c] = ~ch_enable[c];
        if (!ch_enable[c] && ($urandom % 4) == 0) ch_center[c] = 1'($urandom % 2);
        if (($urandom % 50) == 0) ch_invert[c] = ~ch_invert[c];
      end
      if (($urandom % 300) == 0) prescale = 16'($urandom % 5);
      if (it == 1500) begin
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_pwm", 64'(pwm_out), 64'd0);
        check("async_reset_sample", 64'(sample_out), 64'd0);
        check("async_reset_valid", 64'(sample_valid), 64'd0);
        model_reset();
      end
      @(negedge clk);
      check("rand_pwm_out", 64'(pwm_out), 64'(m_pwm));
      check("rand_sample_out", 64'(sample_out), 64'(m_sample));
      check("rand_sample_valid", 64'(sample_valid), 64'(m_valid));
      if (!reset_n) reset_n = 1'b1;
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
